dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-side memory and MMIO bridge that sits directly downstream of the pipelined ARM core's memory stage. It consumes the core's `MemWrite`, `ALUResult` and `WriteData` and returns `ReadData` in the same cycle. It contains the word-addressed data RAM plus a small peripheral set: LED register, free-running cycle counter with compare/match interrupt, and a one-entry byte transmit holding register with a valid/ready handshake.

## Interface

Parameters:

- `DEPTH`, 64: RAM size in 32-bit words; power of two, 16 to 4096.

Ports:

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all registers except RAM contents.
- `MemWrite` input 1: write strobe from the core's memory stage.
- `ALUResult` input 32: byte address.
- `WriteData` input 32: store data.
- `ReadData` output 32: load data, combinational from the current address.
- `leds` output 8: LED register.
- `irq` output 1: equals STATUS.match.
- `tx_data` output 8: pending transmit byte.
- `tx_valid` output 1: a transmit byte is pending.
- `tx_ready` input 1: the consumer accepts the byte on an edge where `tx_valid && tx_ready`.

## Operation

Address decode ignores `ALUResult[1:0]`; all accesses are full-word.

- RAM window: `ALUResult[31:16] == 16'h0000` and `ALUResult < 4*DEPTH`. Word index is `ALUResult[log2(DEPTH)+1:2]`. Accesses in the 0x0000_xxxx region beyond the RAM read 0, and writes there are ignored.
- 0xFFFF_0000 LED: read/write. Reads return `{24'b0, leds}`; writes load `WriteData[7:0]`.
- 0xFFFF_0004 COUNTER: reads return the current value. A write loads `WriteData`; a load takes priority over the increment on the same edge. Otherwise the counter increments by 1 every cycle and wraps 0xFFFF_FFFF→0.
- 0xFFFF_0008 COMPARE: read/write, 32 bits.
- 0xFFFF_000C STATUS, reads `{29'b0, ovf, tx_pending, match}`:
  - match: set on any edge where COUNTER (registered value, before update) equals COMPARE; sticky.
  - ovf: sticky.
  - Writes clear each bit whose `WriteData` bit is 1 (bit0 match, bit2 ovf). If a set and a clear hit the same edge, the set wins.
- 0xFFFF_0010 TXDATA: reads return `{23'b0, tx_pending, tx_data}`. A write is accepted if `tx_pending == 0`, or if a handshake completes on the same edge. When accepted, it loads `WriteData[7:0]` and sets `tx_pending`; otherwise the write is dropped and `ovf` is set.
- Any other 0xFFFF_xxxx address, and any other region, reads 0 with writes ignored.
- `tx_valid = tx_pending`. A handshake edge clears `tx_pending` unless an accepted TXDATA write on the same edge re-sets it.
- `tx_data` is held stable while `tx_valid` is high.

## Timing

- Reads are combinational: `ReadData` is valid in the same cycle as `ALUResult`. There is no stall path, and there are no wait states.
- Writes take effect on the rising edge at which `MemWrite` is high. A read of the same address in the next cycle returns the new value.
- RAM write-then-read latency is 1 edge. There is no read-during-write forwarding, since reads are asynchronous from the array.
- match asserts one edge after COUNTER equals COMPARE. `irq` follows STATUS.match with no additional delay.
- Reset (async, any time, including mid-handshake) forces:
  - `leds=0`, COUNTER=0, COMPARE=0xFFFF_FFFF, match=0, ovf=0, `tx_pending=0`, `tx_data=0`.
  - `ReadData` then reflects the reset register values.
  - RAM contents are unchanged by reset and undefined at power-up.
- During reset the counter does not count. It counts from 0 starting at the first edge after `reset` deasserts.

## Test plan

- **RAM round-trip.** Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 → both return 0xDEADBEEF. Read 0x0000_0100 (DEPTH=64) → 0. A write to 0x0000_0100 leaves RAM word 0 unchanged.
- **LED and unmapped.** Write 0x1234_56A5 to 0xFFFF_0000 → `leds=0xA5`, readback 0x0000_00A5. Read 0xFFFF_0020 → 0.
- **Counter/compare.**
  - Write COMPARE=20, then load COUNTER=10 → `irq` rises exactly 11 edges after the load edge.
  - Write STATUS=1 on the same edge the match recurs (COUNTER reloaded to 20) → match stays 1.
  - Write STATUS=1 alone → match clears.
- **TX handshake.**
  - Hold `tx_ready=0` and write TXDATA=0x41 → `tx_valid=1`, `tx_data=0x41`.
  - Write 0x42 → dropped; `tx_data` stays 0x41 and STATUS=0x6.
  - Raise `tx_ready` for one cycle → `tx_valid` falls.
- **Back-to-back TX.** With `tx_ready=1` continuously, write 0x10 then 0x11 on consecutive cycles → both accepted, `ovf` stays 0, and the consumer sees 0x10 then 0x11.
- **Reset mid-operation.** Assert `reset` asynchronously between edges while `tx_pending=1` and COUNTER=500 → outputs immediately go to `tx_valid=0`, `leds=0`, `irq=0`. COUNTER reads 0, and RAM word 0x10 still reads 0xDEADBEEF.

Source files
------------

// File: rtl/dmem_bridge_if.sv
// Core/consumer-facing bus of the data memory bridge: load/store port plus
// LED, interrupt and byte-transmit handshake signals.
interface dmem_bridge_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic        irq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // bridge side
  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, leds, irq, tx_data, tx_valid
  );

  // core / consumer side
  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, leds, irq, tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_bridge.sv
// Data-side RAM plus MMIO peripherals (LED, cycle counter with compare
// interrupt, one-entry transmit holding register). Reads are combinational,
// writes land on the rising edge with MemWrite high.
module dmem_bridge #(
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  dmem_bridge_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [7:0]  led_q;
  logic [31:0] cnt_q, cmp_q;
  logic        match_q, ovf_q, txp_q;
  logic [7:0]  txd_q;

  logic [31:0] a;
  logic        ram_sel, io_sel;
  logic [AW-1:0] widx;
  logic        wr_led, wr_cnt, wr_cmp, wr_sts, wr_tx;
  logic        hs, tx_acc, ovf_set, match_set;
  logic [31:0] rdata;

  assign a       = bus.ALUResult;
  assign ram_sel = (a[31:16] == 16'h0000) && (a[15:0] < 16'(4*DEPTH));
  assign io_sel  = (a[31:16] == 16'hFFFF);
  assign widx    = a[AW+1:2];

  // byte-lane bits are don't-care: every access is a full word
  logic unused_lsb;
  assign unused_lsb = &{1'b0, a[1:0]};

  assign wr_led = bus.MemWrite && io_sel && (a[15:2] == 14'd0);
  assign wr_cnt = bus.MemWrite && io_sel && (a[15:2] == 14'd1);
  assign wr_cmp = bus.MemWrite && io_sel && (a[15:2] == 14'd2);
  assign wr_sts = bus.MemWrite && io_sel && (a[15:2] == 14'd3);
  assign wr_tx  = bus.MemWrite && io_sel && (a[15:2] == 14'd4);

  // a handshake frees the slot on the same edge, so a back-to-back write fits
  assign hs        = txp_q && bus.tx_ready;
  assign tx_acc    = wr_tx && (!txp_q || hs);
  assign ovf_set   = wr_tx && !tx_acc;
  assign match_set = (cnt_q == cmp_q);

  // RAM array write port; contents deliberately survive reset
  always_ff @(posedge clk)
    if (bus.MemWrite && ram_sel) mem[widx] <= bus.WriteData;

  // peripheral registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= 8'h00;
      cnt_q   <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      txp_q   <= 1'b0;
      txd_q   <= 8'h00;
    end else begin
      if (wr_led) led_q <= bus.WriteData[7:0];
      cnt_q <= wr_cnt ? bus.WriteData : cnt_q + 32'd1;
      if (wr_cmp) cmp_q <= bus.WriteData;
      // set beats a same-edge clear
      match_q <= match_set | (match_q & ~(wr_sts & bus.WriteData[0]));
      ovf_q   <= ovf_set   | (ovf_q   & ~(wr_sts & bus.WriteData[2]));
      if (tx_acc) begin
        txp_q <= 1'b1;
        txd_q <= bus.WriteData[7:0];
      end else if (hs) begin
        txp_q <= 1'b0;
      end
    end
  end

  // combinational read mux
  always_comb begin
    rdata = 32'h0;
    if (ram_sel) rdata = mem[widx];
    else if (io_sel) begin
      case (a[15:2])
        14'd0:   rdata = {24'b0, led_q};
        14'd1:   rdata = cnt_q;
        14'd2:   rdata = cmp_q;
        14'd3:   rdata = {29'b0, ovf_q, txp_q, match_q};
        14'd4:   rdata = {23'b0, txp_q, txd_q};
        default: rdata = 32'h0;
      endcase
    end
  end

  assign bus.ReadData = rdata;
  assign bus.leds     = led_q;
  assign bus.irq      = match_q;
  assign bus.tx_data  = txd_q;
  assign bus.tx_valid = txp_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: RAM, LED, counter/compare, TX handshake,
// asynchronous reset.
module tb_dmem_bridge;
  localparam logic [31:0] LED = 32'hFFFF_0000;
  localparam logic [31:0] CNT = 32'hFFFF_0004;
  localparam logic [31:0] CMP = 32'hFFFF_0008;
  localparam logic [31:0] STS = 32'hFFFF_000C;
  localparam logic [31:0] TXD = 32'hFFFF_0010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dmem_bridge_if bus();

  dmem_bridge #(.DEPTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] got_q[$];

  // consumer: log every byte taken on a handshake edge
  always @(posedge clk)
    if (!reset && bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    bus.ALUResult = addr;
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d);
    bus.ALUResult = addr;
    bus.MemWrite  = 1'b0;
    #1;
    d = bus.ReadData;
  endtask

  logic [31:0] r;
  int n;

  initial begin
    bus.MemWrite = 1'b0; bus.ALUResult = 32'h0; bus.WriteData = 32'h0; bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_leds", {24'b0, bus.leds}, 32'h0);
    chk("rst_txv", {31'b0, bus.tx_valid}, 32'h0);
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    rd(CMP, r); chk("rst_cmp", r, 32'hFFFF_FFFF);
    rd(CNT, r); chk("rst_cnt_held", r, 32'h0);
    rd(STS, r); chk("rst_sts", r, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // RAM round-trip and out-of-window accesses
    wr(32'h0000_0000, 32'h1234_5678);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, r); chk("ram_10", r, 32'hDEAD_BEEF);
    rd(32'h0000_0013, r); chk("ram_13", r, 32'hDEAD_BEEF);
    rd(32'h0000_0100, r); chk("ram_oob", r, 32'h0);
    wr(32'h0000_0100, 32'hFFFF_FFFF);
    rd(32'h0000_0000, r); chk("ram_w0_kept", r, 32'h1234_5678);
    rd(32'h0001_0000, r); chk("other_region", r, 32'h0);

    // LED and unmapped MMIO
    wr(LED, 32'h1234_56A5);
    chk("leds", {24'b0, bus.leds}, 32'hA5);
    rd(LED, r); chk("led_rb", r, 32'h0000_00A5);
    rd(32'hFFFF_0020, r); chk("unmapped", r, 32'h0);

    // counter/compare: irq rises 11 edges after loading 10 with compare 20
    wr(CMP, 32'd20);
    wr(CNT, 32'd10);
    n = 0;
    while (!bus.irq && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("irq_latency", n, 11);
    wr(STS, 32'h1);
    chk("match_clr0", {31'b0, bus.irq}, 32'h0);
    wr(CNT, 32'd20);
    wr(STS, 32'h1);
    chk("set_wins", {31'b0, bus.irq}, 32'h1);
    wr(STS, 32'h1);
    chk("match_clr", {31'b0, bus.irq}, 32'h0);
    rd(CNT, r); chk("cnt_run", r, 32'd22);

    // TX holding register
    bus.tx_ready = 1'b0;
    wr(TXD, 32'h41);
    chk("tx_valid", {31'b0, bus.tx_valid}, 32'h1);
    chk("tx_data", {24'b0, bus.tx_data}, 32'h41);
    rd(TXD, r); chk("tx_rb", r, 32'h141);
    wr(TXD, 32'h42);
    chk("tx_drop", {24'b0, bus.tx_data}, 32'h41);
    rd(STS, r); chk("sts_ovf", r, 32'h6);
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b0;
    chk("tx_done", {31'b0, bus.tx_valid}, 32'h0);
    wr(STS, 32'h4);
    rd(STS, r); chk("ovf_clr", r, 32'h0);

    // back-to-back TX with consumer always ready
    got_q.delete();
    bus.tx_ready = 1'b1;
    wr(TXD, 32'h10);
    wr(TXD, 32'h11);
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b0;
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b2b_0", {24'b0, got_q[0]}, 32'h10);
      chk("b2b_1", {24'b0, got_q[1]}, 32'h11);
    end
    rd(STS, r); chk("b2b_sts", r, 32'h0);

    // asynchronous reset mid-operation
    wr(LED, 32'hFF);
    wr(TXD, 32'h55);
    wr(CMP, 32'd499);
    wr(CNT, 32'd499);
    @(posedge clk);
    #1;
    rd(CNT, r); chk("pre_cnt", r, 32'd500);
    chk("pre_irq", {31'b0, bus.irq}, 32'h1);
    chk("pre_txv", {31'b0, bus.tx_valid}, 32'h1);
    reset = 1'b1;
    #1;
    chk("ar_txv", {31'b0, bus.tx_valid}, 32'h0);
    chk("ar_leds", {24'b0, bus.leds}, 32'h0);
    chk("ar_irq", {31'b0, bus.irq}, 32'h0);
    rd(CNT, r); chk("ar_cnt", r, 32'h0);
    rd(32'h0000_0010, r); chk("ar_ram", r, 32'hDEAD_BEEF);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    rd(CNT, r); chk("cnt_after_rst", r, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
